video_timing_gen: RTL and testbench

- Parametrised successor to the fixed-720p video signal generator that drives the HDMI pipeline.
- Produces pixel coordinates, sync, active-draw, new-frame strobe and frame counter for any raster: porches, sync widths, sync polarity and frame-count wrap are all set by parameters.
- Adds a pixel-enable (pause) input.
- Optional lookahead coordinates for pipelined sprite/ROM reads ahead of the TMDS encoders.

---
 rtl/video_timing_gen.sv | 134 +++++++++++++
 tb/tb_video_timing_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: coordinates, sync, active-draw, new-frame strobe and frame count.
// Defining VIDEO_TIMING_GEN_LOOKAHEAD_EN adds lookahead coordinates LOOKAHEAD enabled pixels ahead.
module video_timing_gen #(
    parameter int H_ACTIVE  = 1280,
    parameter int H_FP      = 110,
    parameter int H_SYNC    = 40,
    parameter int H_BP      = 220,
    parameter int V_ACTIVE  = 720,
    parameter int V_FP      = 5,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 20,
    parameter bit HS_POL    = 1'b1,
    parameter bit VS_POL    = 1'b1,
    parameter int FC_WIDTH  = 6,
    parameter int FC_WRAP   = 60,
    parameter int LOOKAHEAD = 2,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic                clk_pixel_in,
    input  logic                rst_in,
    input  logic                en_in,
    output logic [HW-1:0]       hcount_out,
    output logic [VW-1:0]       vcount_out,
    output logic                hs_out,
    output logic                vs_out,
    output logic                ad_out,
    output logic                nf_out,
    output logic [FC_WIDTH-1:0] fc_out
`ifdef VIDEO_TIMING_GEN_LOOKAHEAD_EN
    ,
    output logic [HW-1:0]       la_hcount_out,
    output logic [VW-1:0]       la_vcount_out
`endif
);

    localparam logic [HW-1:0]       H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]       V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [FC_WIDTH-1:0] FC_LAST  = FC_WIDTH'(FC_WRAP - 1);
    localparam logic [31:0]         HA       = 32'(H_ACTIVE);
    localparam logic [31:0]         VA       = 32'(V_ACTIVE);
    localparam logic [31:0]         HS_START = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0]         HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0]         VS_START = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0]         VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

    if (LOOKAHEAD < 1 || LOOKAHEAD >= H_TOTAL) begin : g_bad_lookahead
        $error("video_timing_gen: LOOKAHEAD out of range");
    end
    if (FC_WRAP < 1 || FC_WRAP > (1 << FC_WIDTH)) begin : g_bad_fc_wrap
        $error("video_timing_gen: FC_WRAP does not fit FC_WIDTH");
    end

    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    logic [31:0]   h_wide;
    logic [31:0]   v_wide;
    logic          ad_next;
    logic          hs_next;
    logic          vs_next;
    logic          nf_next;

    // Flags are decoded from the position the raster is about to enter, so they
    // line up with the coordinates registered on the same edge.
    always_comb begin
        h_next = hcount_out + HW'(1);
        v_next = vcount_out;
        if (hcount_out == H_LAST) begin
            h_next = '0;
            v_next = (vcount_out == V_LAST) ? '0 : vcount_out + VW'(1);
        end
        h_wide  = 32'(h_next);
        v_wide  = 32'(v_next);
        ad_next = (h_wide < HA) && (v_wide < VA);
        hs_next = ((h_wide >= HS_START) && (h_wide < HS_END)) ? HS_POL : ~HS_POL;
        vs_next = ((v_wide >= VS_START) && (v_wide < VS_END)) ? VS_POL : ~VS_POL;
        nf_next = (h_wide == HA) && (v_wide == VA);
    end

    always_ff @(posedge clk_pixel_in or negedge rst_in) begin
        if (!rst_in) begin
            hcount_out <= H_LAST;
            vcount_out <= V_LAST;
            hs_out     <= ~HS_POL;
            vs_out     <= ~VS_POL;
            ad_out     <= 1'b0;
            nf_out     <= 1'b0;
            fc_out     <= '0;
        end else if (en_in) begin
            hcount_out <= h_next;
            vcount_out <= v_next;
            hs_out     <= hs_next;
            vs_out     <= vs_next;
            ad_out     <= ad_next;
            nf_out     <= nf_next;
            if (nf_next) begin
                fc_out <= (fc_out == FC_LAST) ? '0 : fc_out + FC_WIDTH'(1);
            end
        end else begin
            nf_out <= 1'b0;
        end
    end

`ifdef VIDEO_TIMING_GEN_LOOKAHEAD_EN
    localparam logic [HW-1:0] LA_H0 = HW'((LOOKAHEAD - 1) % H_TOTAL);
    localparam logic [VW-1:0] LA_V0 = VW'(((LOOKAHEAD - 1) / H_TOTAL) % V_TOTAL);

    logic [HW-1:0] la_h_next;
    logic [VW-1:0] la_v_next;

    // The lookahead counter is an independent copy of the raster started LOOKAHEAD pixels ahead.
    always_comb begin
        la_h_next = la_hcount_out + HW'(1);
        la_v_next = la_vcount_out;
        if (la_hcount_out == H_LAST) begin
            la_h_next = '0;
            la_v_next = (la_vcount_out == V_LAST) ? '0 : la_vcount_out + VW'(1);
        end
    end

    always_ff @(posedge clk_pixel_in or negedge rst_in) begin
        if (!rst_in) begin
            la_hcount_out <= LA_H0;
            la_vcount_out <= LA_V0;
        end else if (en_in) begin
            la_hcount_out <= la_h_next;
            la_vcount_out <= la_v_next;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: a small raster (H 8/2/2/2, V 4/1/1/1, active-low syncs,
// FC wrap 4) and a default 720p instance run side by side against per-pixel frame-position models.
module tb_video_timing_gen;

    localparam int S_HT = 14;
    localparam int S_VT = 7;
    localparam int S_FRAME = S_HT * S_VT;
    localparam int S_NF = 4 * S_HT + 8;
    localparam int B_HT = 1650;
    localparam int B_VT = 750;
    localparam int B_FRAME = B_HT * B_VT;
    localparam int B_NF = 720 * B_HT + 1280;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic en_s;
    logic en_b;

    logic [3:0]  s_h;
    logic [2:0]  s_v;
    logic        s_hs, s_vs, s_ad, s_nf;
    logic [1:0]  s_fc;
    logic [10:0] b_h;
    logic [9:0]  b_v;
    logic        b_hs, b_vs, b_ad, b_nf;
    logic [5:0]  b_fc;
`ifdef VIDEO_TIMING_GEN_LOOKAHEAD_EN
    logic [3:0]  s_lah;
    logic [2:0]  s_lav;
    logic [10:0] b_lah;
    logic [9:0]  b_lav;
`endif

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .FC_WIDTH(2), .FC_WRAP(4), .LOOKAHEAD(3)
    ) dutSmall (
        .clk_pixel_in(clk),
        .rst_in(rst_n),
        .en_in(en_s),
        .hcount_out(s_h),
        .vcount_out(s_v),
        .hs_out(s_hs),
        .vs_out(s_vs),
        .ad_out(s_ad),
        .nf_out(s_nf),
        .fc_out(s_fc)
`ifdef VIDEO_TIMING_GEN_LOOKAHEAD_EN
        ,
        .la_hcount_out(s_lah),
        .la_vcount_out(s_lav)
`endif
    );

    video_timing_gen dutBig (
        .clk_pixel_in(clk),
        .rst_in(rst_n),
        .en_in(en_b),
        .hcount_out(b_h),
        .vcount_out(b_v),
        .hs_out(b_hs),
        .vs_out(b_vs),
        .ad_out(b_ad),
        .nf_out(b_nf),
        .fc_out(b_fc)
`ifdef VIDEO_TIMING_GEN_LOOKAHEAD_EN
        ,
        .la_hcount_out(b_lah),
        .la_vcount_out(b_lav)
`endif
    );

    int checks = 0;
    int failures = 0;

    int ps, fcs, nfs;
    int pb, fcb, nfb;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, observed, expected);
        end
    endtask

    task automatic modelReset();
        ps = S_FRAME - 1;
        pb = B_FRAME - 1;
        nfs = 0;
        nfb = 0;
        fcs = 0;
        fcb = 0;
    endtask

    task automatic modelStep();
        if (!rst_n) begin
            modelReset();
        end else begin
            if (en_s) begin
                ps  = (ps + 1) % S_FRAME;
                nfs = (ps == S_NF) ? 1 : 0;
                if (nfs == 1) fcs = (fcs + 1) % 4;
            end else begin
                nfs = 0;
            end
            if (en_b) begin
                pb  = (pb + 1) % B_FRAME;
                nfb = (pb == B_NF) ? 1 : 0;
                if (nfb == 1) fcb = (fcb + 1) % 60;
            end else begin
                nfb = 0;
            end
        end
    endtask

    task automatic checkAll();
        int h, v;
        h = ps % S_HT;
        v = ps / S_HT;
        checkOutput("s_hcount", 32'(s_h), h);
        checkOutput("s_vcount", 32'(s_v), v);
        checkOutput("s_ad", 32'(s_ad), (h < 8 && v < 4) ? 1 : 0);
        checkOutput("s_hs", 32'(s_hs), (h >= 10 && h < 12) ? 0 : 1);
        checkOutput("s_vs", 32'(s_vs), (v == 5) ? 0 : 1);
        checkOutput("s_nf", 32'(s_nf), nfs);
        checkOutput("s_fc", 32'(s_fc), fcs);
`ifdef VIDEO_TIMING_GEN_LOOKAHEAD_EN
        checkOutput("s_la_h", 32'(s_lah), ((ps + 3) % S_FRAME) % S_HT);
        checkOutput("s_la_v", 32'(s_lav), ((ps + 3) % S_FRAME) / S_HT);
`endif
        h = pb % B_HT;
        v = pb / B_HT;
        checkOutput("b_hcount", 32'(b_h), h);
        checkOutput("b_vcount", 32'(b_v), v);
        checkOutput("b_ad", 32'(b_ad), (h < 1280 && v < 720) ? 1 : 0);
        checkOutput("b_hs", 32'(b_hs), (h >= 1390 && h < 1430) ? 1 : 0);
        checkOutput("b_vs", 32'(b_vs), (v >= 725 && v < 730) ? 1 : 0);
        checkOutput("b_nf", 32'(b_nf), nfb);
        checkOutput("b_fc", 32'(b_fc), fcb);
`ifdef VIDEO_TIMING_GEN_LOOKAHEAD_EN
        checkOutput("b_la_h", 32'(b_lah), ((pb + 2) % B_FRAME) % B_HT);
        checkOutput("b_la_v", 32'(b_lav), ((pb + 2) % B_FRAME) / B_HT);
`endif
    endtask

    task automatic applyStimulus(input bit es, input bit eb, input int n);
        en_s = es;
        en_b = eb;
        repeat (n) begin
            @(posedge clk);
            #1;
            modelStep();
            checkAll();
        end
    endtask

    initial begin
        int found;
        int fcBefore;
        rst_n = 1'b0;
        en_s  = 1'b1;
        en_b  = 1'b1;
        modelReset();
        #12;
        checkOutput("s_rst_h", 32'(s_h), 13);
        checkOutput("s_rst_v", 32'(s_v), 6);
        checkOutput("s_rst_hs", 32'(s_hs), 1);
        checkOutput("b_rst_h", 32'(b_h), 1649);
        checkOutput("b_rst_v", 32'(b_v), 749);
        checkOutput("b_rst_hsvs", 32'({b_hs, b_vs}), 0);
        checkAll();

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkAll();
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("s_first_hv", 32'({s_h, s_v}), 0);
        checkOutput("b_first_ad", 32'(b_ad), 1);

        // 720p first line plus a little; small raster runs 17 frames, wrapping fc repeatedly.
        applyStimulus(1'b1, 1'b1, 1699);
        checkOutput("b_line1_v", 32'(b_v), 1);

        found = 0;
        for (int i = 0; i < 2000 && (pb % B_HT) != 100; i++) applyStimulus(1'b1, 1'b1, 1);
        if ((pb % B_HT) == 100) found = 1;
        checkOutput("b_reach_h100", found, 1);
        applyStimulus(1'b1, 1'b0, 7);
        checkOutput("b_frozen_h", 32'(b_h), 100);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("b_resume_h", 32'(b_h), 101);

        found = 0;
        for (int i = 0; i < 200 && nfs == 0; i++) applyStimulus(1'b1, 1'b1, 1);
        if (nfs == 1) found = 1;
        checkOutput("s_reach_nf", found, 1);
        fcBefore = fcs;
        applyStimulus(1'b0, 1'b1, 3);
        checkOutput("s_nf_dropped", 32'(s_nf), 0);
        applyStimulus(1'b1, 1'b1, 20);
        checkOutput("s_fc_once", 32'(s_fc), fcBefore);

        for (int i = 0; i < 240; i++) applyStimulus(bit'(i % 3 != 1), bit'(i % 4 != 0), 1);

        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        checkOutput("s_async_h", 32'(s_h), 13);
        applyStimulus(1'b1, 1'b1, 2);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("s_rerelease_ad", 32'(s_ad), 1);
        applyStimulus(1'b1, 1'b1, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
